// File: rtl/rooth_int_ctrl_if.sv
// rtl/rooth_int_ctrl_if.sv - request/ack/eoi handshake between interrupt controller and core
interface rooth_int_ctrl_if #(
    parameter int ID_W = 3
);
    logic            int_req_o;
    logic [ID_W-1:0] int_id_o;
    logic            int_ack_i;
    logic            int_eoi_i;

    modport master (
        output int_req_o,
        output int_id_o,
        input  int_ack_i,
        input  int_eoi_i
    );

    modport slave (
        input  int_req_o,
        input  int_id_o,
        output int_ack_i,
        output int_eoi_i
    );
endinterface

// File: rtl/rooth_int_ctrl.sv
// rtl/rooth_int_ctrl.sv - edge-latched, fixed-priority, non-nesting interrupt controller
module rooth_int_ctrl #(
    parameter int INT_NUM = 8,
    parameter int ID_W    = 3,
    parameter int SYNC_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [INT_NUM-1:0] int_en_i,
    input  logic               gie_i,
    rooth_int_ctrl_if.master   bus,
    output logic [INT_NUM-1:0] int_pending_o,
    output logic               int_busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d, sel;
    logic [INT_NUM-1:0] s, prev_q, pend_q, pend_d, edge_v, elig, id_hit;
    logic [1:0]         warm_q;
    logic               armed, cur_en;

    if (SYNC_EN != 0) begin : g_sync
        logic [INT_NUM-1:0] sync1_q, sync2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= int_flag_i;
                sync2_q <= sync1_q;
            end
        end
        assign s = sync2_q;
    end else begin : g_nosync
        assign s = int_flag_i;
    end

    // Edges stay masked until prev holds a real sample, so a line already
    // high at reset release must fall and rise again to be seen.
    localparam int WARM = (SYNC_EN != 0) ? 3 : 1;
    assign armed  = (warm_q == 2'(WARM));
    assign edge_v = armed ? (s & ~prev_q) : '0;
    assign elig   = gie_i ? (pend_q & int_en_i) : '0;

    always_comb begin
        id_hit = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            id_hit[i] = (id_q == ID_W'(i));
        end
    end
    assign cur_en = |(int_en_i & id_hit);

    always_comb begin
        sel = '0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (elig[i]) sel = ID_W'(i);
        end
    end

    // Set has priority over the ack-driven clear so a same-cycle edge survives.
    always_comb begin
        pend_d = pend_q;
        if (state_q == REQ && bus.int_ack_i) pend_d = pend_q & ~id_hit;
        pend_d = pend_d | edge_v;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    id_d    = sel;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack_i) begin
                    req_d   = 1'b0;
                    state_d = SERVICE;
                end else if (!gie_i || !cur_en) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.int_eoi_i) state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            prev_q  <= s;
            if (!armed) warm_q <= warm_q + 2'd1;
        end
    end

    assign bus.int_req_o = req_q;
    assign bus.int_id_o  = id_q;
    assign int_pending_o = pend_q;
    assign int_busy_o    = (state_q != IDLE);
endmodule

// File: tb/tb_rooth_int_ctrl.sv
// tb/tb_rooth_int_ctrl.sv - self-checking bench for rooth_int_ctrl with behavioural model
module tb_rooth_int_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] flag = 8'h00;
    logic [7:0] en = 8'hFF;
    logic       gie = 1'b1;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic [7:0] pend;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // model: phase 0 = waiting, 1 = requesting, 2 = in service
    int         m_phase;
    int         m_id;
    bit         m_req;
    bit         m_armed;
    logic [7:0] m_pend;
    logic [7:0] m_prev;

    always #5 clk = ~clk;

    rooth_int_ctrl_if #(.ID_W(3)) bus ();
    assign bus.int_ack_i = ack;
    assign bus.int_eoi_i = eoi;

    rooth_int_ctrl #(.INT_NUM(8), .ID_W(3), .SYNC_EN(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .int_flag_i    (flag),
        .int_en_i      (en),
        .gie_i         (gie),
        .bus           (bus),
        .int_pending_o (pend),
        .int_busy_o    (busy)
    );

    task automatic model_reset();
        m_phase = 0; m_id = 0; m_req = 0; m_armed = 0;
        m_pend = 8'h00; m_prev = 8'h00;
    endtask

    // Advance the reference model using the inputs present at the coming edge, then clock.
    task automatic tick();
        logic [7:0] rises, cleared, elig;
        int low;
        rises   = m_armed ? (flag & ~m_prev) : 8'h00;
        cleared = (m_phase == 1 && ack) ? 8'(1 << m_id) : 8'h00;
        elig    = gie ? (m_pend & en) : 8'h00;
        if (m_phase == 0) begin
            if (elig != 0) begin
                low = int'(elig) & -int'(elig);
                m_id = $clog2(low);
                m_req = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_req = 0; m_phase = 2;
            end else if (!gie || !en[m_id]) begin
                m_req = 0; m_phase = 0;
            end
        end else if (eoi) begin
            m_phase = 0;
        end
        m_pend  = (m_pend & ~cleared) | rises;
        m_prev  = flag;
        m_armed = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({bus.int_req_o, bus.int_id_o, busy, pend} !== 13'h0) begin
            errors++;
            $display("FAIL reset got req=%b id=%0d busy=%b pend=%h exp all 0", bus.int_req_o, bus.int_id_o, busy, pend);
        end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        flag = 8'h08; tick();
        checks++;
        if (pend !== 8'h08 || bus.int_req_o !== 1'b0) begin
            errors++; $display("FAIL single_pend got pend=%h req=%b exp 08 0", pend, bus.int_req_o);
        end
        flag = 8'h00; tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL single_req got req=%b id=%0d busy=%b exp 1 3 1", bus.int_req_o, bus.int_id_o, busy);
        end
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (bus.int_req_o !== 1'b0 || pend !== 8'h00 || busy !== 1'b1) begin
            errors++; $display("FAIL single_ack got req=%b pend=%h busy=%b exp 0 00 1", bus.int_req_o, pend, busy);
        end
        tick(); tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.int_req_o !== 1'b0) begin
            errors++; $display("FAIL single_eoi got busy=%b req=%b exp 0 0", busy, bus.int_req_o);
        end
    endtask

    task automatic test_priority();
        flag = 8'h24; tick(); flag = 8'h00; tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd2) begin
            errors++; $display("FAIL prio_first got req=%b id=%0d exp 1 2", bus.int_req_o, bus.int_id_o);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (pend !== 8'h20) begin
            errors++; $display("FAIL prio_pend got %h exp 20", pend);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.int_req_o !== 1'b0) begin
            errors++; $display("FAIL prio_idle_gap got busy=%b req=%b exp 0 0", busy, bus.int_req_o);
        end
        tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd5) begin
            errors++; $display("FAIL prio_second got req=%b id=%0d exp 1 5", bus.int_req_o, bus.int_id_o);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++;
        if (pend !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL prio_end got pend=%h busy=%b exp 00 0", pend, busy);
        end
    endtask

    task automatic test_mask();
        en = 8'hFB;
        flag = 8'h04; tick(); flag = 8'h00; tick(); tick();
        checks++;
        if (pend !== 8'h04 || bus.int_req_o !== 1'b0) begin
            errors++; $display("FAIL mask_hold got pend=%h req=%b exp 04 0", pend, bus.int_req_o);
        end
        en = 8'hFF; tick(); tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd2) begin
            errors++; $display("FAIL mask_release got req=%b id=%0d exp 1 2", bus.int_req_o, bus.int_id_o);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_withdraw();
        flag = 8'h10; tick(); flag = 8'h00; tick();
        gie = 1'b0; tick();
        checks++;
        if (bus.int_req_o !== 1'b0 || busy !== 1'b0 || pend !== 8'h10) begin
            errors++; $display("FAIL withdraw got req=%b busy=%b pend=%h exp 0 0 10", bus.int_req_o, busy, pend);
        end
        gie = 1'b1; tick(); tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd4) begin
            errors++; $display("FAIL withdraw_rereq got req=%b id=%0d exp 1 4", bus.int_req_o, bus.int_id_o);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_set_wins();
        flag = 8'h02; tick(); flag = 8'h00; tick();
        flag = 8'h02; ack = 1'b1; tick(); flag = 8'h00; ack = 1'b0;
        checks++;
        if (pend !== 8'h02 || busy !== 1'b1 || bus.int_req_o !== 1'b0) begin
            errors++; $display("FAIL set_wins got pend=%h busy=%b req=%b exp 02 1 0", pend, busy, bus.int_req_o);
        end
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd1) begin
            errors++; $display("FAIL set_wins_rereq got req=%b id=%0d exp 1 1", bus.int_req_o, bus.int_id_o);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++;
        if (pend !== 8'h00) begin
            errors++; $display("FAIL set_wins_end got pend=%h exp 00", pend);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) flag = 8'($urandom);
            if ($urandom_range(0, 15) == 0) en = 8'($urandom);
            gie = ($urandom_range(0, 9) != 0);
            ack = bus.int_req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            eoi = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (bus.int_req_o !== m_req || bus.int_id_o !== 3'(m_id) || pend !== m_pend || busy !== (m_phase != 0)) begin
                errors++;
                $display("FAIL random cyc=%0d got req=%b id=%0d pend=%h busy=%b exp req=%b id=%0d pend=%h busy=%b",
                         c, bus.int_req_o, bus.int_id_o, pend, busy, m_req, m_id, m_pend, m_phase != 0);
            end
        end
        flag = 8'h00; en = 8'hFF; gie = 1'b1; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic test_async_reset();
        flag = 8'h20; tick(); flag = 8'h00; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        flag = 8'h40; tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.int_req_o, bus.int_id_o, busy, pend} !== 13'h0) begin
            errors++; $display("FAIL async_reset got req=%b id=%0d busy=%b pend=%h exp all 0", bus.int_req_o, bus.int_id_o, busy, pend);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bus.int_req_o !== 1'b0 || pend !== 8'h00) begin
            errors++; $display("FAIL held_line got req=%b pend=%h exp 0 00", bus.int_req_o, pend);
        end
        flag = 8'h00; tick();
        flag = 8'h40; tick(); flag = 8'h00; tick();
        checks++;
        if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd6) begin
            errors++; $display("FAIL held_line_toggle got req=%b id=%0d exp 1 6", bus.int_req_o, bus.int_id_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_withdraw();
        test_set_wins();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rooth_int_ctrl.md
Name: rooth_int_ctrl

Overview:
Interrupt controller between the SoC external interrupt lines (int_flag_i) and the rooth core trap logic.
- Latches rising edges of each source into a pending register.
- Masks pending bits with per-source and global enables, and selects one source by fixed priority.
- Presents the selected source to the core with a req/ack handshake, then blocks further requests until the core signals end-of-interrupt (mret).
- No nesting.

Parameters:
INT_NUM, 8, number of interrupt sources (1..8).
ID_W, 3, width of int_id_o; must satisfy 2**ID_W >= INT_NUM.
SYNC_EN, 1, 1 = two-flop synchronizer on int_flag_i; 0 = inputs treated as already synchronous to clk.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
int_flag_i  input  INT_NUM  raw interrupt lines, active high.
int_en_i  input  INT_NUM  per-source enable (CSR mie image).
gie_i  input  1  global interrupt enable (mstatus.MIE).
int_ack_i  input  1  core has taken the trap for int_id_o.
int_eoi_i  input  1  core executed mret; one-cycle pulse.
int_req_o  output  1  interrupt request to core.
int_id_o  output  ID_W  source index of the current request / in-service interrupt.
int_pending_o  output  INT_NUM  pending register (CSR mip image).
int_busy_o  output  1  high in REQ or SERVICE state.

Behaviour:
Reset (asynchronous, rst_n=0):
- int_req_o=0, int_id_o=0, int_pending_o=0, int_busy_o=0.
- Synchronizer and edge-history flops cleared to 0; FSM=IDLE.
- A line already high when reset releases does not create an edge until it falls and rises again.

Input path:
- s = int_flag_i delayed 2 cycles (SYNC_EN=1) or undelayed (SYNC_EN=0).
- prev = s registered.
- edge[i] = s[i] & ~prev[i].

Pending register, per bit, evaluated each clock:
- Set if edge[i].
- Clear if (state==REQ & int_ack_i & int_id_o==i).
- Set wins over clear in the same cycle, so the edge is not lost.
- Pending bits latch regardless of int_en_i and gie_i.

Eligibility and priority:
- elig = pending & int_en_i, valid only when gie_i=1.
- Fixed priority: lowest index wins; sel = index of lowest set bit of elig.

FSM, registered outputs:
- IDLE:
  - If gie_i & |elig: int_id_o<=sel, int_req_o<=1, go to REQ.
  - Latency: edge on s in cycle N -> pending at N+1 -> int_req_o high at N+2 (plus 2 cycles with SYNC_EN=1).
- REQ:
  - int_id_o frozen; int_req_o held high.
  - If int_ack_i: int_req_o<=0, go to SERVICE; the pending bit for int_id_o clears (subject to the set-wins rule).
  - Else if gie_i=0 or int_en_i[int_id_o]=0: withdraw, int_req_o<=0, go to IDLE; pending kept.
  - Ack takes priority over withdraw in the same cycle.
- SERVICE:
  - int_req_o=0; int_id_o holds the in-service source.
  - New edges still latch into pending.
  - On int_eoi_i: go to IDLE. Re-arbitration happens the next cycle, so there is at least one IDLE cycle between SERVICE and the next REQ.
- int_busy_o = (state != IDLE).

Ignored events:
- int_ack_i outside REQ.
- int_eoi_i outside SERVICE.

Widths:
- int_id_o is zero-extended to ID_W.
- Sources at index >= INT_NUM do not exist.

Test Plan:
1. SYNC_EN=0, gie=1, en=8'hFF; pulse int_flag_i[3] at cycle 10 -> pending=8'h08 at 11, req=1 and id=3 at 12; ack at 14 -> req=0 and pending=0 at 15; eoi at 18 -> busy=0 at 19.
2. Rising edges on bits 2 and 5 in the same cycle -> id=2 first; after ack and eoi, id=5 is requested with at least 1 idle cycle between; pending ends at 0.
3. en=8'hFB, edge on bit 2 -> pending=8'h04, req stays 0; set en=8'hFF -> req=1, id=2 two cycles later.
4. In REQ for id=4, drop gie_i with no ack -> req=0 next cycle, state IDLE, pending[4] still 1; raise gie_i -> re-request id=4.
5. In REQ for id=1, new edge on bit 1 in the ack cycle -> pending[1] stays 1; after eoi, a second request for id=1 is issued.
6. Assert rst_n=0 mid-SERVICE (not clock-aligned) -> req, id, pending and busy go to 0 immediately; hold line 6 high across reset release -> no request until it toggles low then high.
